trig_request_sequencer: RTL

- Shares one combinational sine lookup ROM (9-bit degree angle in, signed Q16.16 sine out) between N_REQ requesters, such as camera yaw, camera pitch and entity rotation logic.
- For each accepted request the block performs two ROM lookups in sequence: sin(angle), then cos(angle) computed as sin(angle+90).
- It returns both results as a single response with the requester ID.
- It sits between the per-frame rotation/projection logic and the single shared sine ROM instance.

---
 rtl/trig_request_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/trig_request_sequencer.sv
// Shares one combinational sine ROM among N_REQ requesters. Each accepted request
// gets two back-to-back lookups, sin(a) and sin(a+90), returned as one response.
module trig_request_sequencer #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [9*N_REQ-1:0]   req_angle,
  output logic [N_REQ-1:0]     req_ready,
  output logic [8:0]           rom_angle,
  input  logic [31:0]          rom_sin_value,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W-1:0]      resp_id,
  output logic [31:0]          resp_sin,
  output logic [31:0]          resp_cos
);

  localparam int unsigned NR = N_REQ;

  typedef enum logic [1:0] {IDLE, LOOK_SIN, LOOK_COS, RESP} state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] id_q;
  logic [8:0]      angle_q;
  logic [31:0]     sin_q;
  logic [31:0]     cos_q;

  logic            gnt_found;
  logic [ID_W-1:0] gnt_idx;
  logic [8:0]      gnt_angle;
  logic [8:0]      norm_angle;
  logic            handshake;
  int unsigned     cand;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = 0;
    for (int unsigned i = 0; i < NR; i++) begin
      cand = 32'(ptr_q) + 32'd1 + i;
      if (cand >= NR) cand = cand - NR;
      if (!gnt_found && req_valid[ID_W'(cand)]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    gnt_angle = '0;
    for (int unsigned j = 0; j < NR; j++) begin
      if (ID_W'(j) == gnt_idx) gnt_angle = req_angle[9*j +: 9];
    end
  end

  // Inputs never exceed 511, so one conditional subtraction lands in 0..359.
  assign norm_angle = (gnt_angle >= 9'd360) ? gnt_angle - 9'd360 : gnt_angle;
  assign handshake  = (state_q == IDLE) && gnt_found && Reset_n;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (handshake) state_d = LOOK_SIN;
      LOOK_SIN: state_d = LOOK_COS;
      LOOK_COS: state_d = RESP;
      RESP:     if (resp_ready) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = '0;
    rom_angle  = '0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE:     if (handshake) req_ready[gnt_idx] = 1'b1;
      LOOK_SIN: rom_angle = angle_q;
      // Cosine address wraps at 360; the 10-bit sum keeps a_n + 90 from overflowing.
      LOOK_COS: rom_angle = (angle_q < 9'd270) ? 9'({1'b0, angle_q} + 10'd90)
                                               : 9'({1'b0, angle_q} - 10'd270);
      RESP:     resp_valid = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr_q   <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      angle_q <= '0;
      sin_q   <= '0;
      cos_q   <= '0;
    end else begin
      if (handshake) begin
        ptr_q   <= gnt_idx;
        id_q    <= gnt_idx;
        angle_q <= norm_angle;
      end
      if (state_q == LOOK_SIN) sin_q <= rom_sin_value;
      if (state_q == LOOK_COS) cos_q <= rom_sin_value;
    end
  end

  assign resp_id  = id_q;
  assign resp_sin = sin_q;
  assign resp_cos = cos_q;

endmodule
